// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one word-level memory port between instruction fetch (IF) and
// load/store (LS). One transaction at a time: IDLE -> BUSY -> ACK -> IDLE.
// LS has fixed priority, except that after STARVE_LIMIT consecutive LS grants
// with a fetch pending, the fetch is granted. A flushed fetch still completes
// downstream, but its response is discarded.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i       fetch request and address
//   if_flush_i               cancel a granted, unacknowledged fetch
//   if_ack_o/if_data_o/if_pc_o   fetch response strobe, word and its address
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_size_i   load/store request
//   ls_ack_o/ls_rdata_o      load/store completion strobe and load data
//   m_req_o/m_we_o/m_addr_o/m_wdata_o/m_size_o        downstream request
//   m_done_i/m_rdata_i       downstream completion and read data
//   busy_o                   high while in BUSY or ACK
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  output logic [31:0] if_pc_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [1:0]  ls_size_i,
  output logic        ls_ack_o,
  output logic [31:0] ls_rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [1:0]  m_size_o,
  input  logic        m_done_i,
  input  logic [31:0] m_rdata_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t           r_state, w_state_nxt;
  owner_t           r_owner;
  logic [CNT_W-1:0] r_starve;
  logic             r_drop;

  logic             r_if_ack, r_ls_ack;
  logic [31:0]      r_if_data, r_if_pc, r_ls_rdata;
  logic             r_m_req, r_m_we;
  logic [31:0]      r_m_addr, r_m_wdata;
  logic [1:0]       r_m_size;

  logic             w_grant_ls, w_grant_if;
  logic [1:0]       w_ls_size;

  // Illegal size 2 is forwarded downstream as a word access.
  assign w_ls_size = (ls_size_i == 2'd2) ? 2'd3 : ls_size_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ls  = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A fetch flushed in the same cycle is not granted, even when the
        // starvation limit has locked LS out.
        if (ls_req_i && (!if_req_i || (r_starve < LIMIT))) begin
          w_grant_ls  = 1'b1;
          w_state_nxt = S_BUSY;
        end else if (if_req_i && !if_flush_i) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY:  if (m_done_i) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= OWN_IF;
      r_starve   <= '0;
      r_drop     <= 1'b0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_if_data  <= '0;
      r_if_pc    <= '0;
      r_ls_rdata <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_size   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;

      if (w_grant_ls) begin
        r_owner   <= OWN_LS;
        r_m_req   <= 1'b1;
        r_m_we    <= ls_we_i;
        r_m_addr  <= ls_addr_i;
        r_m_wdata <= ls_wdata_i;
        r_m_size  <= w_ls_size;
        if (!if_req_i)             r_starve <= '0;
        else if (r_starve < LIMIT) r_starve <= r_starve + 1'b1;
      end

      if (w_grant_if) begin
        r_owner   <= OWN_IF;
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_addr  <= if_addr_i;
        r_m_wdata <= '0;
        r_m_size  <= 2'd3;
        r_starve  <= '0;
      end

      if (r_state == S_BUSY) begin
        if ((r_owner == OWN_IF) && if_flush_i) r_drop <= 1'b1;
        if (m_done_i) begin
          r_m_req <= 1'b0;
          if (r_owner == OWN_LS) begin
            r_ls_ack <= 1'b1;
            if (!r_m_we) r_ls_rdata <= m_rdata_i;
          end else begin
            if (!r_drop && !if_flush_i) begin
              r_if_ack  <= 1'b1;
              r_if_data <= m_rdata_i;
              r_if_pc   <= r_m_addr;
            end
            // Completion ends the fetch either way; overrides the set above.
            r_drop <= 1'b0;
          end
        end
      end
    end
  end

  assign if_ack_o   = r_if_ack;
  assign if_data_o  = r_if_data;
  assign if_pc_o    = r_if_pc;
  assign ls_ack_o   = r_ls_ack;
  assign ls_rdata_o = r_ls_rdata;
  assign m_req_o    = r_m_req;
  assign m_we_o     = r_m_we;
  assign m_addr_o   = r_m_addr;
  assign m_wdata_o  = r_m_wdata;
  assign m_size_o   = r_m_size;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (STARVE_LIMIT = 4). The bench plays the
// memory controller: it pulses m_done_i with chosen read data. Inputs change
// 1 ns after a rising edge; outputs are sampled at that point too.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_data_o, if_pc_o;
  logic        ls_req_i, ls_we_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic [1:0]  ls_size_i;
  logic        ls_ack_o;
  logic [31:0] ls_rdata_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [1:0]  m_size_o;
  logic        m_done_i;
  logic [31:0] m_rdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_if_data, exp_if_pc, exp_ls_rdata;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_data_o(if_data_o), .if_pc_o(if_pc_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_size_i(ls_size_i),
    .ls_ack_o(ls_ack_o), .ls_rdata_o(ls_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_size_o(m_size_o),
    .m_done_i(m_done_i), .m_rdata_i(m_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a downstream request.
  task automatic wait_mreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_req_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One-cycle completion pulse; returns 1 ns after the sampling edge.
  task automatic do_done(input logic [31:0] data);
    m_done_i  = 1'b1;
    m_rdata_i = data;
    step();
    m_done_i  = 1'b0;
    m_rdata_i = '0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h100; if_flush_i = 1'b0;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h2000;
    ls_wdata_i = 32'h0; ls_size_i = 2'd3;
    m_done_i = 1'b0; m_rdata_i = '0;
    repeat (3) step();
    checks++;
    if ({m_req_o, m_we_o, busy_o, if_ack_o, ls_ack_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b we=%b busy=%b ifack=%b lsack=%b, want all 0",
               m_req_o, m_we_o, busy_o, if_ack_o, ls_ack_o);
    end
    checks++;
    if ({m_addr_o, m_wdata_o, m_size_o, if_data_o, if_pc_o, ls_rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h size=%0d ifdata=%h ifpc=%h lsrdata=%h, want 0",
               m_addr_o, m_wdata_o, m_size_o, if_data_o, if_pc_o, ls_rdata_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_noreq: got m_req=%b want 0", m_req_o);
    end
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h2000) begin
      errors++;
      $display("FAIL first_grant_ls: got req=%b addr=%h want req=1 addr=00002000", m_req_o, m_addr_o);
    end
    do_done(32'hCAFE);
    exp_ls_rdata = 32'hCAFE;
    checks++;
    if (ls_ack_o !== 1'b1 || ls_rdata_o !== exp_ls_rdata || if_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL first_load_ack: got lsack=%b rdata=%h ifack=%b want 1 %h 0",
               ls_ack_o, ls_rdata_o, if_ack_o, exp_ls_rdata);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    bit ok;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h100 || m_size_o !== 2'd3 || m_we_o !== 1'b0 ||
        m_wdata_o !== 32'h0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue: got req=%b addr=%h size=%0d we=%b wdata=%h busy=%b want 1 00000100 3 0 0 1",
               m_req_o, m_addr_o, m_size_o, m_we_o, m_wdata_o, busy_o);
    end
    repeat (3) step();
    checks++;
    if (m_req_o !== 1'b1 || m_addr_o !== 32'h100 || if_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold: got req=%b addr=%h ifack=%b want 1 00000100 0",
               m_req_o, m_addr_o, if_ack_o);
    end
    do_done(32'h13);
    exp_if_data = 32'h13; exp_if_pc = 32'h100;
    checks++;
    if (if_ack_o !== 1'b1 || if_data_o !== exp_if_data || if_pc_o !== exp_if_pc ||
        m_req_o !== 1'b0 || ls_ack_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ack: got ack=%b data=%h pc=%h req=%b lsack=%b busy=%b want 1 %h %h 0 0 1",
               if_ack_o, if_data_o, if_pc_o, m_req_o, ls_ack_o, busy_o, exp_if_data, exp_if_pc);
    end
    if_req_i = 1'b0;
    step();
    checks++;
    if (if_ack_o !== 1'b0 || busy_o !== 1'b0 || if_data_o !== exp_if_data) begin
      errors++;
      $display("FAIL fetch_after: got ack=%b busy=%b data=%h want 0 0 %h",
               if_ack_o, busy_o, if_data_o, exp_if_data);
    end
  endtask

  task automatic test_priority();
    bit ok;
    bit got_if;
    logic [5:0] exp_if;
    logic [31:0] data;
    exp_if = 6'b010000;  // grant g is IF when bit g is set: LS,LS,LS,LS,IF,LS
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h4000; ls_size_i = 2'd3;
    if_req_i = 1'b1; if_addr_i = 32'h180;
    for (int g = 0; g < 6; g++) begin
      wait_mreq(ok);
      got_if = (m_addr_o == 32'h180);
      checks++;
      if (!ok || got_if !== exp_if[g]) begin
        errors++;
        $display("FAIL prio_grant%0d: got req=%b is_if=%b want req=1 is_if=%b",
                 g, m_req_o, got_if, exp_if[g]);
      end
      data = 32'h1000 + 32'(g);
      do_done(data);
      if (exp_if[g]) begin
        exp_if_data = data; exp_if_pc = 32'h180;
        checks++;
        if (if_ack_o !== 1'b1 || ls_ack_o !== 1'b0 || if_data_o !== exp_if_data || if_pc_o !== exp_if_pc) begin
          errors++;
          $display("FAIL prio_ack%0d: got ifack=%b lsack=%b data=%h pc=%h want 1 0 %h %h",
                   g, if_ack_o, ls_ack_o, if_data_o, if_pc_o, exp_if_data, exp_if_pc);
        end
      end else begin
        exp_ls_rdata = data;
        checks++;
        if (ls_ack_o !== 1'b1 || if_ack_o !== 1'b0 || ls_rdata_o !== exp_ls_rdata) begin
          errors++;
          $display("FAIL prio_ack%0d: got lsack=%b ifack=%b rdata=%h want 1 0 %h",
                   g, ls_ack_o, if_ack_o, ls_rdata_o, exp_ls_rdata);
        end
      end
      if (g == 5) begin
        ls_req_i = 1'b0; if_req_i = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_flush();
    bit ok;
    // Flush in the same cycle as the request: never granted.
    if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 32'h500;
    step();
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_nogrant: got req=%b busy=%b want 0 0", m_req_o, busy_o);
    end
    if_flush_i = 1'b0; if_addr_i = 32'h200;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL flush_issue: got req=%b addr=%h want 1 00000200", m_req_o, m_addr_o);
    end
    if_flush_i = 1'b1; if_addr_i = 32'h300;
    step();
    if_flush_i = 1'b0;
    step();
    do_done(32'hDEAD);
    checks++;
    if (if_ack_o !== 1'b0 || if_data_o !== exp_if_data || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_noack: got ack=%b data=%h req=%b want 0 %h 0",
               if_ack_o, if_data_o, m_req_o, exp_if_data);
    end
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h300) begin
      errors++;
      $display("FAIL flush_refetch: got req=%b addr=%h want 1 00000300", m_req_o, m_addr_o);
    end
    do_done(32'h93);
    exp_if_data = 32'h93; exp_if_pc = 32'h300;
    checks++;
    if (if_ack_o !== 1'b1 || if_data_o !== exp_if_data || if_pc_o !== exp_if_pc) begin
      errors++;
      $display("FAIL flush_refetch_ack: got ack=%b data=%h pc=%h want 1 %h %h",
               if_ack_o, if_data_o, if_pc_o, exp_if_data, exp_if_pc);
    end
    // Flush on the same edge as done: response discarded.
    if_addr_i = 32'h400;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h400) begin
      errors++;
      $display("FAIL flush_edge_issue: got req=%b addr=%h want 1 00000400", m_req_o, m_addr_o);
    end
    if_flush_i = 1'b1;
    do_done(32'hBEEF);
    if_flush_i = 1'b0; if_addr_i = 32'h600;
    checks++;
    if (if_ack_o !== 1'b0 || if_data_o !== exp_if_data || if_pc_o !== exp_if_pc) begin
      errors++;
      $display("FAIL flush_edge_noack: got ack=%b data=%h pc=%h want 0 %h %h",
               if_ack_o, if_data_o, if_pc_o, exp_if_data, exp_if_pc);
    end
    // The following fetch must be acked normally.
    step();
    wait_mreq(ok);
    do_done(32'h55);
    exp_if_data = 32'h55; exp_if_pc = 32'h600;
    checks++;
    if (!ok || if_ack_o !== 1'b1 || if_data_o !== exp_if_data || if_pc_o !== exp_if_pc) begin
      errors++;
      $display("FAIL flush_next_ack: got ok=%b ack=%b data=%h pc=%h want 1 1 %h %h",
               ok, if_ack_o, if_data_o, if_pc_o, exp_if_data, exp_if_pc);
    end
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_byte_store();
    bit ok;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h1003;
    ls_wdata_i = 32'hAB; ls_size_i = 2'd2;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_size_o !== 2'd3 || m_we_o !== 1'b1 || m_addr_o !== 32'h1003 || m_wdata_o !== 32'hAB) begin
      errors++;
      $display("FAIL store_illegal_size: got req=%b size=%0d we=%b addr=%h wdata=%h want 1 3 1 00001003 000000ab",
               m_req_o, m_size_o, m_we_o, m_addr_o, m_wdata_o);
    end
    do_done(32'h5555);
    checks++;
    if (ls_ack_o !== 1'b1 || ls_rdata_o !== exp_ls_rdata) begin
      errors++;
      $display("FAIL store_ack1: got ack=%b rdata=%h want 1 %h", ls_ack_o, ls_rdata_o, exp_ls_rdata);
    end
    ls_size_i = 2'd0;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_size_o !== 2'd0 || m_we_o !== 1'b1 || m_wdata_o !== 32'hAB) begin
      errors++;
      $display("FAIL store_byte: got req=%b size=%0d we=%b wdata=%h want 1 0 1 000000ab",
               m_req_o, m_size_o, m_we_o, m_wdata_o);
    end
    do_done(32'h6666);
    checks++;
    if (ls_ack_o !== 1'b1 || ls_rdata_o !== exp_ls_rdata) begin
      errors++;
      $display("FAIL store_ack2: got ack=%b rdata=%h want 1 %h", ls_ack_o, ls_rdata_o, exp_ls_rdata);
    end
    ls_req_i = 1'b0; ls_we_i = 1'b0;
    step();
    checks++;
    if (ls_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL store_after: got ack=%b busy=%b want 0 0", ls_ack_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h8000; ls_size_i = 2'd3;
    step();
    wait_mreq(ok);
    checks++;
    if (!ok || m_addr_o !== 32'h8000) begin
      errors++;
      $display("FAIL midrst_issue: got req=%b addr=%h want 1 00008000", m_req_o, m_addr_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b0 || m_addr_o !== 32'h0 ||
        ls_rdata_o !== 32'h0 || if_data_o !== 32'h0 || if_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: got req=%b busy=%b addr=%h lsrdata=%h ifdata=%h ifpc=%h want all 0",
               m_req_o, busy_o, m_addr_o, ls_rdata_o, if_data_o, if_pc_o);
    end
    ls_req_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_done(32'h77);
    checks++;
    if (ls_ack_o !== 1'b0 || if_ack_o !== 1'b0 || ls_rdata_o !== 32'h0 || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late_done: got lsack=%b ifack=%b rdata=%h req=%b want 0 0 0 0",
               ls_ack_o, if_ack_o, ls_rdata_o, m_req_o);
    end
  endtask

  initial begin
    exp_if_data = '0; exp_if_pc = '0; exp_ls_rdata = '0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_flush();
    test_byte_store();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
